// File: rtl/mon_pkg.sv
// Shared definitions for the serial monitor register bank.
//   mon_state_t     : frame controller states (idle / shifting)
//   MON_CNT_W       : bit-counter width; covers a 65-bit frame (64 data + parity)
//   mon_snap_ofs()  : snapshot register offset from BASE_ADDR (= NCH)
//   mon_rel_ofs()   : release register offset from BASE_ADDR (= NCH+1)
//   mon_odd_par()   : odd-parity bit over a zero-extended data word
package mon_pkg;

    typedef enum logic [0:0] {
        MON_IDLE  = 1'b0,
        MON_SHIFT = 1'b1
    } mon_state_t;

    localparam int MON_CNT_W = 7;

    function automatic int mon_snap_ofs(input int nch);
        return nch;
    endfunction

    function automatic int mon_rel_ofs(input int nch);
        return nch + 1;
    endfunction

    // Zero-extension does not change the XOR, so any WIDTH up to 64 fits.
    function automatic logic mon_odd_par(input logic [63:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/mon_shift_ctrl.sv
// Frame controller: bit counter, IDLE/SHIFT state machine, busy/done status.
// Ports:
//   bclk, rstb : clock, asynchronous active-low reset
//   load       : channel hit, (re)starts a frame of fl bits
//   shift      : qualified shift strobe (already excludes any register hit)
//   fl         : frame length in bits
//   busy       : frame in progress
//   done       : one-cycle pulse after the last frame bit has shifted
module mon_shift_ctrl
    import mon_pkg::*;
#(
    parameter int CW = MON_CNT_W
) (
    input  logic          bclk,
    input  logic          rstb,
    input  logic          load,
    input  logic          shift,
    input  logic [CW-1:0] fl,
    output logic          busy,
    output logic          done
);

    mon_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge bclk or negedge rstb) begin
        if (!rstb) begin
            state <= MON_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            MON_IDLE: begin
                // Shifting while idle moves zeros only; counter untouched.
                if (load) begin
                    state_nxt = MON_SHIFT;
                    cnt_nxt   = fl;
                end
            end
            MON_SHIFT: begin
                if (load) begin
                    // Restart wins over a shift in the same cycle, no done.
                    cnt_nxt = fl;
                end else if (shift) begin
                    if (cnt == CW'(1)) begin
                        state_nxt = MON_IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = MON_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == MON_SHIFT);

endmodule

// File: rtl/mon_regbank_ro.sv
// Read-only monitor register bank on the serial monitor path.
// NCH channels of WIDTH bits; a latch at BASE_ADDR+k loads channel k (live or
// from the frozen snapshot) into a shifter that is clocked out MSB first.
// BASE_ADDR+NCH captures a snapshot of all channels, BASE_ADDR+NCH+1 releases it.
// Build option: MON_PARITY_EN appends an odd-parity bit as the last frame bit.
// Ports:
//   bclk, rstb : clock, asynchronous active-low reset
//   dataIn     : channel k = dataIn[k*WIDTH +: WIDTH]
//   addrIn     : register address, qualifies latchOut
//   latchOut   : load strobe
//   shiftEn    : shift strobe, one bit per cycle
//   shiftOut   : serial data (shifter MSB)
//   busy, done : frame in progress / one-cycle end-of-frame pulse
//   frozen     : snapshot is being served
module mon_regbank_ro
    import mon_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         NCH       = 4,
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic               bclk,
    input  logic               rstb,
    input  logic [NCH*WIDTH-1:0] dataIn,
    input  logic [7:0]         addrIn,
    input  logic               latchOut,
    input  logic               shiftEn,
    output logic               shiftOut,
    output logic               busy,
    output logic               done,
    output logic               frozen
);

`ifdef MON_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [MON_CNT_W-1:0] FL = MON_CNT_W'(SW);

    if (int'(BASE_ADDR) + mon_rel_ofs(NCH) > 255) begin : g_addr_range
        $error("mon_regbank_ro: release address exceeds 8'hFF");
    end

    logic [SW-1:0]        shifter;
    logic [NCH*WIDTH-1:0] shadow;
    logic [WIDTH-1:0]     sel_data;
    logic [SW-1:0]        load_word;
    int                   addr_ofs;
    logic                 hit_ch, hit_snap, hit_rel, shift_q;

    // Address decode relative to the window base.
    assign addr_ofs = int'(addrIn) - int'(BASE_ADDR);
    assign hit_ch   = latchOut && (addr_ofs >= 0) && (addr_ofs < NCH);
    assign hit_snap = latchOut && (addr_ofs == mon_snap_ofs(NCH));
    assign hit_rel  = latchOut && (addr_ofs == mon_rel_ofs(NCH));
    // Any register hit suppresses the shift for that cycle; misses do not.
    assign shift_q  = shiftEn && !(hit_ch || hit_snap || hit_rel);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (addr_ofs == k)
                sel_data = frozen ? shadow[k*WIDTH +: WIDTH] : dataIn[k*WIDTH +: WIDTH];
        end
    end

`ifdef MON_PARITY_EN
    assign load_word = {sel_data, mon_odd_par(64'(sel_data))};
`else
    assign load_word = sel_data;
`endif

    // NOTE: the shadow bank is reset along with the rest; it is a handful of
    // flops, not a RAM, and a defined snapshot value after reset is required.
    always_ff @(posedge bclk or negedge rstb) begin
        if (!rstb) begin
            shifter <= '0;
            shadow  <= '0;
            frozen  <= 1'b0;
        end else begin
            if (hit_ch)
                shifter <= load_word;
            else if (shift_q)
                shifter <= shifter << 1;
            if (hit_snap) begin
                shadow <= dataIn;
                frozen <= 1'b1;
            end else if (hit_rel) begin
                frozen <= 1'b0;
            end
        end
    end

    assign shiftOut = shifter[SW-1];

    mon_shift_ctrl #(.CW(MON_CNT_W)) u_ctrl (
        .bclk  (bclk),
        .rstb  (rstb),
        .load  (hit_ch),
        .shift (shift_q),
        .fl    (FL),
        .busy  (busy),
        .done  (done)
    );

endmodule

// File: tb/tb_mon_regbank_ro.sv
// Self-checking bench for mon_regbank_ro (WIDTH=32, NCH=4, BASE_ADDR=8'h10).
// Reference model: the frame is a queue of expected bits, popped once per
// effective shiftEn; busy/done/frozen follow from queue occupancy and flags.
module tb_mon_regbank_ro;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int BASE  = 8'h10;
`ifdef MON_PARITY_EN
    localparam int FLB = WIDTH + 1;
`else
    localparam int FLB = WIDTH;
`endif

    logic                 bclk = 1'b0;
    logic                 rstb = 1'b0;
    logic [NCH*WIDTH-1:0] data_in = '0;
    logic [7:0]           addr_in = '0;
    logic                 latch_out = 1'b0;
    logic                 shift_en = 1'b0;
    logic                 shift_out, busy, done, frozen;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit          q[$];
    logic [31:0] shadow_m[NCH];
    bit          frozen_m = 0;
    bit          done_m = 0;

    always #5 bclk = ~bclk;

    mon_regbank_ro #(.WIDTH(WIDTH), .NCH(NCH), .BASE_ADDR(8'h10)) dut (
        .bclk     (bclk),
        .rstb     (rstb),
        .dataIn   (data_in),
        .addrIn   (addr_in),
        .latchOut (latch_out),
        .shiftEn  (shift_en),
        .shiftOut (shift_out),
        .busy     (busy),
        .done     (done),
        .frozen   (frozen)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        frozen_m = 0;
        done_m   = 0;
        for (int k = 0; k < NCH; k++) shadow_m[k] = '0;
    endtask

    // Applies the register-bank rules to the inputs seen at one clock edge.
    task automatic model_edge(input bit l, input logic [7:0] a, input bit s);
        int          o;
        logic [31:0] v;
        o = int'(a) - BASE;
        done_m = 0;
        if (l && o >= 0 && o < NCH) begin
            v = frozen_m ? shadow_m[o] : data_in[o*WIDTH +: WIDTH];
            q.delete();
            for (int b = WIDTH - 1; b >= 0; b--) q.push_back(v[b]);
`ifdef MON_PARITY_EN
            q.push_back(($countones(v) % 2) == 0);
`endif
        end else if (l && o == NCH) begin
            for (int k = 0; k < NCH; k++) shadow_m[k] = data_in[k*WIDTH +: WIDTH];
            frozen_m = 1;
        end else if (l && o == NCH + 1) begin
            frozen_m = 0;
        end else if (s && q.size() > 0) begin
            void'(q.pop_front());
            done_m = (q.size() == 0);
        end
    endtask

    task automatic check_outputs();
        check("shiftOut", shift_out, (q.size() > 0) ? q[0] : 1'b0);
        check("busy",     busy,      q.size() > 0);
        check("done",     done,      done_m);
        check("frozen",   frozen,    frozen_m);
    endtask

    // One clock: drive, take the edge, update the model, compare 1 unit later.
    task automatic cyc(input bit l, input logic [7:0] a, input bit s);
        latch_out = l;
        addr_in   = a;
        shift_en  = s;
        @(posedge bclk);
        model_edge(l, a, s);
        #1;
        latch_out = 1'b0;
        shift_en  = 1'b0;
        check_outputs();
    endtask

    // Shifts one whole frame, collecting bits and counting done pulses.
    task automatic shift_frame(input int gap, output logic [63:0] word, output int dones);
        word  = '0;
        dones = 0;
        for (int i = 0; i < FLB; i++) begin
            word = {word[62:0], shift_out};
            cyc(1'b0, 8'h00, 1'b1);
            dones += int'(done);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 8'h00, 1'b0);
                dones += int'(done);
            end
        end
        cyc(1'b0, 8'h00, 1'b0);
        dones += int'(done);
    endtask

    function automatic logic [31:0] data_of(input logic [63:0] word);
        return 32'(word >> (FLB - WIDTH));
    endfunction

    initial begin
        logic [63:0] word;
        int          dones;
        logic [31:0] v;

        model_reset();
        #12;
        check("reset_shiftOut", shift_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_frozen", frozen, 1'b0);
        rstb = 1'b1;
        @(posedge bclk); #1;

        // 1: channel 2 frame
        data_in[2*WIDTH +: WIDTH] = 32'hA5A5_0F0F;
        cyc(1'b1, 8'h12, 1'b0);
        shift_frame(0, word, dones);
        check("t1_stream", data_of(word), 32'hA5A5_0F0F);
        check("t1_dones", dones, 1);

        // 2: snapshot / release
        data_in[1*WIDTH +: WIDTH] = 32'h1234_5678;
        cyc(1'b1, 8'h14, 1'b0);
        data_in[1*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        cyc(1'b1, 8'h11, 1'b0);
        check("t2_frozen_on", frozen, 1'b1);
        shift_frame(0, word, dones);
        check("t2_snap_stream", data_of(word), 32'h1234_5678);
        cyc(1'b1, 8'h15, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        check("t2_frozen_off", frozen, 1'b0);
        shift_frame(0, word, dones);
        check("t2_live_stream", data_of(word), 32'hFFFF_FFFF);

        // 3: restart mid-frame with latch and shift together
        v = $urandom;
        data_in[0 +: WIDTH] = v;
        cyc(1'b1, 8'h10, 1'b0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            dones += int'(done);
        end
        cyc(1'b1, 8'h10, 1'b1);
        dones += int'(done);
        check("t3_no_early_done", dones, 0);
        shift_frame(0, word, dones);
        check("t3_restart_stream", data_of(word), v);
        check("t3_dones", dones, 1);

        // 4: address miss mid-frame, then async reset mid-frame
        data_in[3*WIDTH +: WIDTH] = $urandom;
        cyc(1'b1, 8'h13, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h20, 1'b1);
        for (int i = 0; i < FLB - 6; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h14, 1'b0);
        cyc(1'b1, 8'h13, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check("t4_rst_shiftOut", shift_out, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_frozen", frozen, 1'b0);
        #3 rstb = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);

`ifdef MON_PARITY_EN
        // 5: parity bit is the last frame bit
        data_in[0 +: WIDTH] = 32'h0000_0001;
        cyc(1'b1, 8'h10, 1'b0);
        shift_frame(0, word, dones);
        check("t5_parity_one", word[0], 1'b0);
        data_in[0 +: WIDTH] = 32'h0000_0000;
        cyc(1'b1, 8'h10, 1'b0);
        shift_frame(0, word, dones);
        check("t5_parity_zero", word[0], 1'b1);
        check("t5_dones", dones, 1);
`endif

        // 6: gapped shifting yields the same stream
        v = $urandom;
        data_in[2*WIDTH +: WIDTH] = v;
        cyc(1'b1, 8'h12, 1'b0);
        shift_frame(3, word, dones);
        check("t6_gap_stream", data_of(word), v);
        check("t6_dones", dones, 1);

        // Random traffic around the address window
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                data_in[$urandom_range(0, NCH-1)*WIDTH +: WIDTH] = $urandom;
            cyc($urandom_range(0, 9) == 0, 8'(8'h0E + $urandom_range(0, 9)),
                $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
